traffic_phase_sched: RTL and testbench
======================================

# traffic_phase_sched

Timed phase scheduler for a two-street intersection (street A, street B) with a pedestrian walk phase and a parade override. It arbitrates the shared crossing between A-side traffic, B-side traffic and pedestrians. It enforces minimum and maximum green, yellow and all-red clearance intervals with an in-state cycle timer. Its 2-bit light codes drive the intersection lamp decoders, and it replaces the untimed sensor-only traffic-light FSM in the lab flow.

## Interface
- MIN_GREEN, 8: minimum green cycles per direction (≥1)
- MAX_GREEN, 32: green cycles after which a contested green is forced to yield (≥ MIN_GREEN)
- YELLOW, 3: yellow cycles (≥1)
- ALL_RED, 2: all-red clearance cycles (≥1)
- WALK, 6: pedestrian walk cycles (≥1)
- CNT_W, 6: timer width; must hold MAX_GREEN-1
- i_clk  in  1  clock; all state changes on rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_t_a  in  1  vehicle present on street A (level)
- i_t_b  in  1  vehicle present on street B (level)
- i_ped  in  1  pedestrian button (any-length pulse, latched)
- i_parade  in  1  parade mode set (pulse)
- i_parade_end  in  1  parade mode clear (pulse)
- o_l_a  out  2  street A lamp: 2'b00 red, 2'b01 yellow, 2'b10 green
- o_l_b  out  2  street B lamp, same coding
- o_walk  out  1  pedestrian walk lamp
- o_state  out  3  current state code (debug)
- o_ped_pending  out  1  latched pedestrian request

## Operation
- States and codes: AG=0, AY=1, RA=2, BG=3, BY=4, RB=5, PW=6. Code 7 is unreachable and recovers to AG on the next edge.
- Moore outputs decoded from the state register:
  - AG: A green.
  - AY: A yellow.
  - BG: B green.
  - BY: B yellow.
  - RA, RB, PW: both lamps red.
  - o_walk is 1 only in PW.
- Timer t:
  - Cleared to 0 on every state change; otherwise increments.
  - In AG and BG, t saturates at MAX_GREEN-1.
- Demand terms:
  - dem_b = i_t_b | ped_pending | parade
  - dem_a = (i_t_a | ped_pending) & !parade
- Transitions:
  - AG→AY when t ≥ MIN_GREEN-1, dem_b is set, and (!i_t_a | t == MAX_GREEN-1 | parade). With no demand, AG holds indefinitely.
  - AY→RA at t == YELLOW-1.
  - RA→PW at t == ALL_RED-1 if ped_pending & !parade; otherwise RA→BG at t == ALL_RED-1.
  - BG→BY: mirror of the AG rule using dem_a and i_t_b. In parade mode, BG never exits.
  - BY→RB at t == YELLOW-1.
  - RB→PW at t == ALL_RED-1 if ped_pending & !parade; otherwise RB→AG at t == ALL_RED-1.
  - PW→BG at t == WALK-1 if entered from RA; PW→AG at t == WALK-1 if entered from RB. A 1-bit last_dir register records the direction.
- ped_pending:
  - Set by i_ped=1 on any edge except while in PW or on the edge entering PW.
  - Cleared on the edge entering PW; a simultaneous press on that edge is absorbed.
- parade:
  - Set by i_parade, cleared by i_parade_end.
  - When both are asserted on the same edge, parade holds its value.
  - Parade does not shorten yellow, all-red or walk intervals already in progress.

## Timing
- Reset (asynchronous, immediate, no clock needed) forces:
  - state=AG, t=0, ped_pending=0, parade=0, last_dir=0
  - o_l_a=2'b10, o_l_b=2'b00, o_walk=0, o_state=0, o_ped_pending=0
- A transition condition true before edge N changes the state at edge N; outputs reflect the new state after edge N.
- Full clearance A→B: YELLOW+ALL_RED cycles of non-green on A before B turns green, i.e. 5 cycles by default.
- Green dwell is between MIN_GREEN and MAX_GREEN cycles while the other direction has demand.
- Inputs are sampled only at rising edges and are assumed synchronous to i_clk.
- Assertion of reset mid-state aborts the phase; after release, the first edge increments t in AG.

## Test plan
- Reset: hold i_rstn=0 for 20 cycles while toggling every input → o_l_a=10, o_l_b=00, o_walk=0, o_state=0 throughout.
- With i_t_a=0 and i_t_b=1 from reset release → 8 cycles AG, 3 cycles AY, 2 cycles RA, then BG (o_l_b=10) on the 13th edge after release. BG then holds with i_t_a=0.
- With i_t_a=i_t_b=1 constant → AG for 32 cycles, then AY/RA, then BG for 32 cycles, then BY/RB, then AG. The cycle repeats with a period of 74.
- One-cycle i_ped pulse in AG with no vehicles:
  - o_ped_pending=1 on the next edge.
  - Sequence AG (until t=7) → AY 3 → RA 2 → PW with o_walk=1 for 6 cycles and o_ped_pending=0 → BG.
- i_parade pulse in AG with i_t_a=1 and repeated i_ped presses for 200 cycles:
  - Sequence reaches BG and stays there with o_walk=0.
  - An i_parade_end pulse then causes BG→BY on the following edge, because t is saturated.
- Assert i_rstn=0 mid-AY between clock edges → outputs return to reset values before the next rising edge. Assert i_parade and i_parade_end together → parade unchanged.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// rtl/traffic_phase_sched.sv - timed two-street phase scheduler with walk phase and parade override
module traffic_phase_sched #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6,
  parameter int CNT_W     = 6
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_t_a,
  input  logic       i_t_b,
  input  logic       i_ped,
  input  logic       i_parade,
  input  logic       i_parade_end,
  output logic [1:0] o_l_a,
  output logic [1:0] o_l_b,
  output logic       o_walk,
  output logic [2:0] o_state,
  output logic       o_ped_pending
);

  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_RA = 3'd2,
    S_BG = 3'd3,
    S_BY = 3'd4,
    S_RB = 3'd5,
    S_PW = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] T_MIN_G  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX_G  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_WALK   = CNT_W'(WALK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             ped_q, ped_d;
  logic             parade_q, parade_d;
  logic             last_dir_q, last_dir_d;   // 0: walk entered from RA, 1: from RB
  logic [1:0]       l_a_q, l_a_d;
  logic [1:0]       l_b_q, l_b_d;
  logic             walk_q, walk_d;

  logic dem_a, dem_b;
  logic enter_pw;

  // Next-state, timer, request latches and lamp decode of the next state
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    dem_b      = i_t_b | ped_q | parade_q;
    dem_a      = (i_t_a | ped_q) & ~parade_q;

    case (state_q)
      S_AG: if ((t_q >= T_MIN_G) && dem_b && (!i_t_a || (t_q == T_MAX_G) || parade_q))
              state_d = S_AY;
      S_AY: if (t_q == T_YELLOW) state_d = S_RA;
      S_RA: if (t_q == T_ALLRED) begin
              if (ped_q && !parade_q) begin
                state_d    = S_PW;
                last_dir_d = 1'b0;
              end else begin
                state_d = S_BG;
              end
            end
      S_BG: if ((t_q >= T_MIN_G) && dem_a && (!i_t_b || (t_q == T_MAX_G) || parade_q))
              state_d = S_BY;
      S_BY: if (t_q == T_YELLOW) state_d = S_RB;
      S_RB: if (t_q == T_ALLRED) begin
              if (ped_q && !parade_q) begin
                state_d    = S_PW;
                last_dir_d = 1'b1;
              end else begin
                state_d = S_AG;
              end
            end
      S_PW: if (t_q == T_WALK) state_d = last_dir_q ? S_AG : S_BG;
      default: state_d = S_AG;   // unused code 7 recovers to A green
    endcase

    // Green timers saturate so a long uncontested green keeps its max-green credit
    if (state_d != state_q)
      t_d = '0;
    else if (((state_q == S_AG) || (state_q == S_BG)) && (t_q == T_MAX_G))
      t_d = t_q;
    else
      t_d = t_q + CNT_W'(1);

    // The walk phase services every press latched so far, including one on the entry edge
    enter_pw = (state_d == S_PW) && (state_q != S_PW);
    if (enter_pw)
      ped_d = 1'b0;
    else if (i_ped && (state_q != S_PW))
      ped_d = 1'b1;
    else
      ped_d = ped_q;

    // Simultaneous set and clear leave parade unchanged
    if (i_parade && !i_parade_end)
      parade_d = 1'b1;
    else if (i_parade_end && !i_parade)
      parade_d = 1'b0;
    else
      parade_d = parade_q;

    l_a_d  = LAMP_RED;
    l_b_d  = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      S_AG:    l_a_d  = LAMP_GREEN;
      S_AY:    l_a_d  = LAMP_YELLOW;
      S_BG:    l_b_d  = LAMP_GREEN;
      S_BY:    l_b_d  = LAMP_YELLOW;
      S_PW:    walk_d = 1'b1;
      default: ;
    endcase
  end

  // Scheduler state and registered Moore outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_AG;
      t_q        <= '0;
      ped_q      <= 1'b0;
      parade_q   <= 1'b0;
      last_dir_q <= 1'b0;
      l_a_q      <= LAMP_GREEN;
      l_b_q      <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      ped_q      <= ped_d;
      parade_q   <= parade_d;
      last_dir_q <= last_dir_d;
      l_a_q      <= l_a_d;
      l_b_q      <= l_b_d;
      walk_q     <= walk_d;
    end
  end

  assign o_l_a         = l_a_q;
  assign o_l_b         = l_b_q;
  assign o_walk        = walk_q;
  assign o_state       = state_q;
  assign o_ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb/tb_traffic_phase_sched.sv - directed self-checking bench for traffic_phase_sched
module tb_traffic_phase_sched;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_t_a = 1'b0;
  logic       i_t_b = 1'b0;
  logic       i_ped = 1'b0;
  logic       i_parade = 1'b0;
  logic       i_parade_end = 1'b0;
  logic [1:0] o_l_a;
  logic [1:0] o_l_b;
  logic       o_walk;
  logic [2:0] o_state;
  logic       o_ped_pending;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_phase_sched dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_t_a        (i_t_a),
    .i_t_b        (i_t_b),
    .i_ped        (i_ped),
    .i_parade     (i_parade),
    .i_parade_end (i_parade_end),
    .o_l_a        (o_l_a),
    .o_l_b        (o_l_b),
    .o_walk       (o_walk),
    .o_state      (o_state),
    .o_ped_pending(o_ped_pending)
  );

  always #5 i_clk = ~i_clk;

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // reset between edges, release between edges, all inputs idle
  task automatic apply_reset();
    i_t_a = 0; i_t_b = 0; i_ped = 0; i_parade = 0; i_parade_end = 0;
    #2;
    i_rstn = 0;
    tick();
    i_rstn = 1;
  endtask

  task automatic test_reset();
    i_rstn = 0;
    for (int i = 0; i < 20; i++) begin
      {i_t_a, i_t_b, i_ped, i_parade, i_parade_end} = 5'($urandom);
      tick();
      n_cmp++;
      if ({o_l_a, o_l_b, o_walk, o_state, o_ped_pending} !== {2'b10, 2'b00, 1'b0, 3'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d: got la=%b lb=%b walk=%b st=%0d ped=%b, want la=10 lb=00 walk=0 st=0 ped=0",
                 i, o_l_a, o_l_b, o_walk, o_state, o_ped_pending);
      end
    end
    apply_reset();
  endtask

  // B demand only: AG 8, AY 3, RA 2, BG from edge 13 and held
  task automatic test_b_only();
    logic [2:0] exp_st;
    apply_reset();
    i_t_b = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_st = (k <= 7) ? 3'd0 : (k <= 10) ? 3'd1 : (k <= 12) ? 3'd2 : 3'd3;
      n_cmp++;
      if (o_state !== exp_st) begin
        n_bad++;
        $display("FAIL b_only_state edge=%0d: got %0d want %0d", k, o_state, exp_st);
      end
    end
    n_cmp++;
    if ({o_l_a, o_l_b} !== {2'b00, 2'b10}) begin
      n_bad++;
      $display("FAIL b_only_lamps: got la=%b lb=%b want la=00 lb=10", o_l_a, o_l_b);
    end
  endtask

  // Both streets loaded: max-green forced yield, period 74
  task automatic test_both_max();
    logic [2:0] exp_st;
    logic [1:0] exp_la, exp_lb;
    int p;
    apply_reset();
    i_t_a = 1; i_t_b = 1;
    for (int k = 1; k <= 160; k++) begin
      tick();
      p = k % 74;
      exp_st = (p < 32) ? 3'd0 : (p < 35) ? 3'd1 : (p < 37) ? 3'd2 :
               (p < 69) ? 3'd3 : (p < 72) ? 3'd4 : 3'd5;
      exp_la = (exp_st == 3'd0) ? 2'b10 : (exp_st == 3'd1) ? 2'b01 : 2'b00;
      exp_lb = (exp_st == 3'd3) ? 2'b10 : (exp_st == 3'd4) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({o_state, o_l_a, o_l_b} !== {exp_st, exp_la, exp_lb}) begin
        n_bad++;
        $display("FAIL both_max edge=%0d: got st=%0d la=%b lb=%b want st=%0d la=%b lb=%b",
                 k, o_state, o_l_a, o_l_b, exp_st, exp_la, exp_lb);
      end
    end
  endtask

  // Pedestrian pulse in idle AG: walk after A clearance, then B green
  task automatic test_ped();
    logic [2:0] exp_st;
    logic       exp_ped, exp_walk;
    apply_reset();
    tick(); tick(); tick();
    i_ped = 1;
    tick();
    i_ped = 0;
    n_cmp++;
    if (o_ped_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL ped_latch: got %b want 1", o_ped_pending);
    end
    for (int k = 5; k <= 30; k++) begin
      tick();
      exp_st   = (k <= 7) ? 3'd0 : (k <= 10) ? 3'd1 : (k <= 12) ? 3'd2 : (k <= 18) ? 3'd6 : 3'd3;
      exp_ped  = (k <= 12);
      exp_walk = (exp_st == 3'd6);
      n_cmp++;
      if ({o_state, o_ped_pending, o_walk} !== {exp_st, exp_ped, exp_walk}) begin
        n_bad++;
        $display("FAIL ped_seq edge=%0d: got st=%0d ped=%b walk=%b want st=%0d ped=%b walk=%b",
                 k, o_state, o_ped_pending, o_walk, exp_st, exp_ped, exp_walk);
      end
    end
  endtask

  // Parade: B green held against A traffic and presses, release after saturation
  task automatic test_parade();
    apply_reset();
    i_t_a = 1;
    tick(); tick();
    i_parade = 1;
    tick();           // edge 3 sets parade
    i_parade = 0;
    for (int k = 4; k <= 13; k++) tick();
    n_cmp++;
    if (o_state !== 3'd3) begin
      n_bad++;
      $display("FAIL parade_reach_bg: got st=%0d want 3", o_state);
    end
    for (int k = 0; k < 200; k++) begin
      i_ped = (k % 10 == 0);
      tick();
      n_cmp++;
      if ({o_state, o_walk} !== {3'd3, 1'b0}) begin
        n_bad++;
        $display("FAIL parade_hold cyc=%0d: got st=%0d walk=%b want st=3 walk=0", k, o_state, o_walk);
      end
    end
    i_ped = 0;
    n_cmp++;
    if (o_ped_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL parade_ped_latched: got %b want 1", o_ped_pending);
    end
    // set and clear together: parade stays on, BG keeps holding
    i_parade = 1; i_parade_end = 1;
    tick();
    i_parade = 0; i_parade_end = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (o_state !== 3'd3) begin
        n_bad++;
        $display("FAIL parade_both_hold cyc=%0d: got st=%0d want 3", k, o_state);
      end
    end
    i_parade_end = 1;
    tick();           // parade cleared at this edge, state unchanged
    i_parade_end = 0;
    n_cmp++;
    if (o_state !== 3'd3) begin
      n_bad++;
      $display("FAIL parade_end_same_edge: got st=%0d want 3", o_state);
    end
    tick();
    n_cmp++;
    if ({o_state, o_l_b} !== {3'd4, 2'b01}) begin
      n_bad++;
      $display("FAIL parade_end_to_by: got st=%0d lb=%b want st=4 lb=01", o_state, o_l_b);
    end
  endtask

  // Simultaneous set/clear with parade off: parade stays off, idle AG holds
  task automatic test_parade_both_off();
    apply_reset();
    i_t_a = 1;
    i_parade = 1; i_parade_end = 1;
    tick();
    i_parade = 0; i_parade_end = 0;
    for (int k = 0; k < 40; k++) tick();
    n_cmp++;
    if ({o_state, o_l_a} !== {3'd0, 2'b10}) begin
      n_bad++;
      $display("FAIL parade_both_off: got st=%0d la=%b want st=0 la=10", o_state, o_l_a);
    end
  endtask

  // Asynchronous reset mid-AY, then a full restart from t=0
  task automatic test_reset_mid();
    logic [2:0] exp_st;
    apply_reset();
    i_t_b = 1;
    for (int k = 1; k <= 9; k++) tick();
    n_cmp++;
    if (o_state !== 3'd1) begin
      n_bad++;
      $display("FAIL mid_pre_ay: got st=%0d want 1", o_state);
    end
    #2;
    i_rstn = 0;
    #1;
    n_cmp++;
    if ({o_l_a, o_l_b, o_walk, o_state, o_ped_pending} !== {2'b10, 2'b00, 1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_async_reset: got la=%b lb=%b walk=%b st=%0d ped=%b want la=10 lb=00 walk=0 st=0 ped=0",
               o_l_a, o_l_b, o_walk, o_state, o_ped_pending);
    end
    tick();
    i_rstn = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_st = (k <= 7) ? 3'd0 : (k <= 10) ? 3'd1 : (k <= 12) ? 3'd2 : 3'd3;
      n_cmp++;
      if (o_state !== exp_st) begin
        n_bad++;
        $display("FAIL mid_restart edge=%0d: got st=%0d want %0d", k, o_state, exp_st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_b_only();
    test_both_max();
    test_ped();
    test_parade();
    test_parade_both_off();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
